// File: rtl/collision_pkg.sv
// Shared constants and types for the player/tile collision scanner.
package collision_pkg;

    localparam int HIT_FLOOR = 0;
    localparam int HIT_CEIL  = 1;
    localparam int HIT_RWALL = 2;
    localparam int HIT_LWALL = 3;

    localparam int DEF_PW = 23;
    localparam int DEF_PH = 45;
    localparam int DEF_TW = 25;
    localparam int DEF_TH = 24;
    localparam int DEF_MG = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } scan_state_e;

endpackage

// File: rtl/collision_scan_box_contact.sv
// One-tile contact test: player box vs tile box, four touch directions.
module box_contact
    import collision_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int PW = DEF_PW,
    parameter int PH = DEF_PH,
    parameter int TW = DEF_TW,
    parameter int TH = DEF_TH,
    parameter int MG = DEF_MG
) (
    input  logic [XW-1:0] px_i,
    input  logic [YW-1:0] py_i,
    input  logic [XW-1:0] tile_x_i,
    input  logic [YW-1:0] tile_y_i,
    input  logic          tile_en_i,
    output logic [3:0]    hit_o
);

    localparam logic [XW:0] PWX = (XW+1)'(PW);
    localparam logic [XW:0] TWX = (XW+1)'(TW);
    localparam logic [XW:0] MGX = (XW+1)'(MG);
    localparam logic [YW:0] PHY = (YW+1)'(PH);
    localparam logic [YW:0] THY = (YW+1)'(TH);
    localparam logic [YW:0] MGY = (YW+1)'(MG);

    // One extra bit so edges past the coordinate range never alias to 0.
    logic [XW:0] p_l, p_r, p_lm, t_l, t_r, t_lm;
    logic [YW:0] p_t, p_b, p_tm, t_t, t_b, t_tm;
    logic        ho, vo;

    assign p_l  = {1'b0, px_i};
    assign p_r  = p_l + PWX;
    assign p_lm = p_l + MGX;
    assign t_l  = {1'b0, tile_x_i};
    assign t_r  = t_l + TWX;
    assign t_lm = t_l + MGX;

    assign p_t  = {1'b0, py_i};
    assign p_b  = p_t + PHY;
    assign p_tm = p_t + MGY;
    assign t_t  = {1'b0, tile_y_i};
    assign t_b  = t_t + THY;
    assign t_tm = t_t + MGY;

    assign ho = (p_r > t_lm) && (p_lm < t_r);
    assign vo = (p_b > t_tm) && (p_tm < t_b);

    always_comb begin
        hit_o = '0;
        if (tile_en_i) begin
            hit_o[HIT_FLOOR] = ho && (p_b == t_t);
            hit_o[HIT_CEIL]  = ho && (p_t == t_b);
            hit_o[HIT_RWALL] = vo && (p_r == t_l);
            hit_o[HIT_LWALL] = vo && (p_l == t_r);
        end
    end

endmodule

// File: rtl/collision_scan.sv
// Scans N_OBJ tiles (one per clock) against the latched player box.
module collision_scan
    import collision_pkg::*;
#(
    parameter int N_OBJ = 8,
    parameter int IW    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int PW    = DEF_PW,
    parameter int PH    = DEF_PH,
    parameter int TW    = DEF_TW,
    parameter int TH    = DEF_TH,
    parameter int MG    = DEF_MG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] py,
    output logic [IW-1:0] tile_idx,
    input  logic [XW-1:0] tile_x,
    input  logic [YW-1:0] tile_y,
    input  logic          tile_en,
    output logic          busy,
    output logic          done,
    output logic [3:0]    hit,
    output logic          land_valid,
    output logic [IW-1:0] land_idx
);

    localparam logic [IW-1:0] LAST = IW'(N_OBJ - 1);

    scan_state_e   state_q;
    logic [XW-1:0] px_q;
    logic [YW-1:0] py_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] eidx_q;
    logic          rd_q;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    hit_q;
    logic          lv_q;
    logic [IW-1:0] li_q;
    logic [3:0]    tile_hit;

    box_contact #(
        .XW(XW), .YW(YW),
        .PW(PW), .PH(PH),
        .TW(TW), .TH(TH),
        .MG(MG)
    ) u_box (
        .px_i      (px_q),
        .py_i      (py_q),
        .tile_x_i  (tile_x),
        .tile_y_i  (tile_y),
        .tile_en_i (tile_en),
        .hit_o     (tile_hit)
    );

    // rd_q/eidx_q track which address the returning table data belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            idx_q   <= '0;
            eidx_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= '0;
            lv_q    <= 1'b0;
            li_q    <= '0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= (state_q == S_SCAN);
            eidx_q <= idx_q;
            if (rd_q) begin
                hit_q <= hit_q | tile_hit;
                if (tile_hit[HIT_FLOOR] && !lv_q) begin
                    lv_q <= 1'b1;
                    li_q <= eidx_q;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        px_q    <= px;
                        py_q    <= py;
                        hit_q   <= '0;
                        lv_q    <= 1'b0;
                        li_q    <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (idx_q == LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tile_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit        = hit_q;
    assign land_valid = lv_q;
    assign land_idx   = li_q;

endmodule
